// File: rtl/hybrid_addsub_serial_pkg.sv
// Shared types and bit-level arithmetic for the hybrid approximate adder.
// Used by the serial unit and by the combinational adder bench model.
package hybrid_addsub_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPROX,
    S_EXACT,
    S_DONE
  } state_t;

  // Width of a counter that must address bits 0..w-1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Reverse-carry approximate cell; returns {c1, sum}.
  function automatic logic [1:0] approx_bit(
    input logic a,
    input logic b,
    input logic c2,
    input logic f1
  );
    logic x;
    logic y;
    x = ~(a & b) & c2;
    y = ~(a | b) | c2;
    return {~((f1 & y) | x), ~((~f1 | x) & y)};
  endfunction

  // Exact full-adder bit; returns {carry, sum}.
  function automatic logic [1:0] fa_bit(
    input logic a,
    input logic b,
    input logic c
  );
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/hybrid_addsub_serial_approx_cell.sv
// Combinational approximate cell, time-multiplexed over the lower bits.
// Thin wrapper over the shared package function.
module approx_cell
  import hybrid_addsub_serial_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_c2,
  input  logic i_f1,
  output logic o_sum,
  output logic o_c1
);

  logic [1:0] w_res;

  assign w_res = approx_bit(i_a, i_b, i_c2, i_f1);
  assign o_sum = w_res[0];
  assign o_c1  = w_res[1];

endmodule

// File: rtl/hybrid_addsub_serial.sv
// Bit-serial hybrid add/subtract: approximate lower region MSB-first,
// then exact ripple upper region LSB-first, with valid/ready on both sides.
module hybrid_addsub_serial
  import hybrid_addsub_serial_pkg::*;
#(
  parameter  int M = 1,
  parameter  int N = 7,
  localparam int W = M + N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] C_TOP  = CW'(M - 1);
  localparam logic [CW-1:0] C_EXA  = CW'(M);
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  state_t r_state;
  state_t w_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_c0;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_s;
  logic          r_cout;

  logic       w_ai;
  logic       w_bi;
  logic       w_f1;
  logic       w_c2;
  logic       w_asum;
  logic       w_ac1;
  logic [1:0] w_fa;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (in_valid)         w_next = S_APPROX;
      S_APPROX: if (r_cnt == '0)      w_next = S_EXACT;
      S_EXACT:  if (r_cnt == C_LAST)  w_next = S_DONE;
      S_DONE:   if (out_ready)        w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  assign w_ai = r_a[r_cnt];
  assign w_bi = r_b[r_cnt];

  // Top approx bit has no upper neighbour; it borrows its own A bit.
  assign w_f1 = (r_cnt == '0) ? r_c0 : r_a[r_cnt - 1'b1];
  assign w_c2 = (r_cnt == C_TOP) ? r_a[M-1] : r_carry;

  approx_cell u_cell (
    .i_a   (w_ai),
    .i_b   (w_bi),
    .i_c2  (w_c2),
    .i_f1  (w_f1),
    .o_sum (w_asum),
    .o_c1  (w_ac1)
  );

  assign w_fa = fa_bit(w_ai, w_bi, r_carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c0    <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b ^ {W{sub}};
            r_c0  <= sub | cin;
            r_cnt <= C_TOP;
          end
        end
        S_APPROX: begin
          r_s[r_cnt] <= w_asum;
          // Exact region is seeded from A[M-1], not the true carry.
          if (r_cnt == '0) begin
            r_carry <= r_a[M-1];
            r_cnt   <= C_EXA;
          end else begin
            r_carry <= w_ac1;
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_EXACT: begin
          r_s[r_cnt] <= w_fa[0];
          r_carry    <= w_fa[1];
          if (r_cnt == C_LAST) r_cout <= w_fa[1];
          else                 r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_hybrid_addsub_serial.sv
// Directed bench for hybrid_addsub_serial at M=1, N=7.
// Expected values are hand-derived from the hybrid cell equations.
module tb_hybrid_addsub_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hybrid_addsub_serial #(.M(1), .N(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge; returns after the accept edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic xc, input logic xs, input string tag);
    @(negedge clk);
    chk({tag, ".irdy0"}, in_ready, 1);
    a = xa;
    b = xb;
    cin = xc;
    sub = xs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'hA5;
    b = 8'h5A;
    cin = ~xc;
    sub = ~xs;
  endtask

  // Cycles counted with the accept cycle as cycle 1.
  task automatic wait_done(output int cyc);
    int k;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid) break;
    end
    cyc = k + 1;
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic xs,
                        input logic [W-1:0] es, input logic ec,
                        input string tag);
    int cyc;
    issue(xa, xb, xc, xs, tag);
    wait_done(cyc);
    chk({tag, ".lat"}, cyc, 9);
    chk({tag, ".s"}, s, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".irdy"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, out_valid, 0);
    chk({tag, ".idle"}, in_ready, 1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.irdy", in_ready, 1);
    chk("rst.ov", out_valid, 0);
    chk("rst.s", s, 0);
    chk("rst.cout", cout, 0);
    rst = 1'b0;

    // out_ready outside DONE must be harmless
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ordy_idle.irdy", in_ready, 1);
    chk("ordy_idle.ov", out_valid, 0);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, "add0f01");
    run_op(8'h02, 8'h01, 1'b0, 1'b0, 8'h03, 1'b0, "add0201");
    run_op(8'h01, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, "approx_err");
    run_op(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, "sub0503");
    run_op(8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, "sub_cin_ign");
    run_op(8'h02, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, "add_cin1");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "wrap");

    // Back-pressure with a stray in_valid pulse while held in DONE
    issue(8'h02, 8'h01, 1'b0, 1'b0, "bp");
    wait_done(cyc);
    chk("bp.lat", cyc, 9);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a = 8'h0F;
      b = 8'h01;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d.s", i), s, 8'h03);
      chk($sformatf("bp%0d.cout", i), cout, 0);
      chk($sformatf("bp%0d.ov", i), out_valid, 1);
      chk($sformatf("bp%0d.irdy", i), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.idle", in_ready, 1);
    chk("bp.ov_clr", out_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp.nocap_irdy", in_ready, 1);
    chk("bp.nocap_ov", out_valid, 0);

    // Reset while the exact region is being processed
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, "rstmid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstmid.busy", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.ov", out_valid, 0);
    chk("rstmid.s", s, 0);
    chk("rstmid.cout", cout, 0);
    chk("rstmid.irdy", in_ready, 1);
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hybrid_addsub_serial.md
Name: hybrid_addsub_serial

Overview:
- Multi-cycle, bit-serial add/subtract unit that evaluates the same hybrid approximate arithmetic as the combinational hybrid adder: an approximate reverse-carry lower region of M bits and an exact ripple upper region of N bits.
- Accepts operands over a valid/ready handshake and processes one bit per cycle: lower region MSB-first, then upper region LSB-first.
- Returns the W-bit result and carry-out over a second valid/ready handshake.
- Serves as the area-minimal sequential counterpart for datapaths that tolerate multi-cycle latency, and adds subtraction.

Parameters:
- M, 1, width of approximate lower region; legal range M>=1.
- N, 7, width of exact upper region; legal range N>=1.
- W, M+N, total operand/result width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit idle and can accept.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B (B inverted, carry-in forced 1).
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- s  out  W  hybrid result.
- cout  out  1  carry out of bit W-1.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, counter=0. Reset overrides any in-flight operation; the partial result is discarded.
- Accept: in_valid & in_ready at an edge latches a, b'=b^{W{sub}}, c0=(sub?1:cin). in_ready drops to 0 the next cycle.
- Approximate cell, for bit g with inputs a, b, c2, f1:
  - x = ~(a&b) & c2
  - y = ~(a|b) | c2
  - sum = ~((~f1|x) & y)
  - c1 = ~((f1&y) | x)
- Neighbour wiring for bit g:
  - c2 = stored c1 of bit g+1; for g=M-1, c2 = A[M-1].
  - f1 = A[g-1]; for g=0, f1 = c0.
- State APPROX: counter runs M-1 down to 0, one cell per cycle. Each cycle writes s[g] and registers c1 for the next (lower) bit.
- State EXACT: carry register initialised to A[M-1]. Counter runs M up to W-1, one full-adder bit per cycle, writing s[g] and the carry. After bit W-1, cout = final carry.
- State DONE: out_valid=1. s and cout are held stable until out_ready=1 at an edge, then state returns to IDLE and in_ready=1.
- Latency: the accept edge, then M+N cycles; out_valid rises on the edge after the last bit. Throughput is one op per M+N+2 cycles minimum.
- Output stability: s is built in place and is not guaranteed meaningful while out_valid=0. In DONE, back-pressure (out_ready=0) holds all outputs indefinitely.
- Boundary conditions:
  - in_valid while busy is ignored; in_ready=0.
  - out_ready asserted outside DONE has no effect.
  - M=1 means APPROX lasts exactly one cycle.
  - All arithmetic is modulo 2^W, with overflow visible only on cout.
  - Inputs a, b, cin and sub may change freely after the accept edge.
- Transitions: IDLE->APPROX on accept; APPROX->EXACT when counter==0; EXACT->DONE when counter==W-1; DONE->IDLE on out_ready.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, APPROX, EXACT, DONE);
  - counter width constant $clog2(W);
  - combinational functions for the approximate cell and the exact full-adder bit, shared with the combinational hybrid adder bench model.
- One natural sub-module: approx_cell, the purely combinational 4-in/2-out cell above. It is instantiated once and time-multiplexed over the M lower bits.

Test Plan (defaults M=1, N=7):
- Add, a=0x0F, b=0x01, cin=0, sub=0: expect s=0x10, cout=0, out_valid exactly 9 cycles after the accept edge.
- Add, a=0x02, b=0x01, cin=0: expect s=0x03, cout=0.
- Approximation error case, a=0x01, b=0x00, cin=0: expect s=0x02 (exact would be 0x01), cout=0.
- Subtract, a=0x05, b=0x03, sub=1: expect s=0x02, cout=1.
- Back-pressure: out_ready=0 for 5 cycles in DONE, with a second in_valid pulse during that time.
  - Expect s and cout held and in_ready=0.
  - On out_ready=1, expect IDLE on the next edge; the second pulse is not captured.
- Reset mid-operation: assert rst during EXACT.
  - On the next edge expect out_valid=0, s=0, cout=0, in_ready=1.
  - A fresh op (0x0F+0x01) then completes correctly with s=0x10.
